// File: rtl/digit_frame_loader.sv
// Frame loader: assembles 784-pixel raster frames in RAM and hands them to the classifier via a valid flag.
// Define FRAME_LOADER_PINGPONG_EN for a second bank so filling overlaps classifier reads.
module digit_frame_loader #(
  parameter int FRAME_PIXELS = 784,
  parameter int PIXEL_W      = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PIXEL_W-1:0] pixel_in_data,
  input  logic               pixel_in_valid,
  input  logic               pixel_in_last,
  output logic               pixel_in_ready,
  input  logic [9:0]         classifier_input_address_a,
  output logic [15:0]        classifier_input_read_data_a,
  output logic [7:0]         classifier_input_valid_read_data,
  input  logic               classifier_input_valid_write_en,
  input  logic [7:0]         classifier_input_valid_write_data,
  output logic               frame_err,
  output logic [15:0]        frame_count
);
  localparam logic [9:0] LAST_PTR = 10'(FRAME_PIXELS - 1);
  localparam logic [9:0] DEPTH    = 10'(FRAME_PIXELS);

  typedef enum logic [0:0] {FILL = 1'b0, HOLD = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [9:0]         wr_ptr_q, wr_ptr_d;
  logic               rd_bank_q, rd_bank_d;
  logic               frame_valid_q, frame_valid_d;
  logic               valid_prev_q;
  logic               commit_q, commit_d;
  logic               frame_err_q, frame_err_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               ready_q, ready_d;
  logic [15:0]        rd_data_q, rd_data_d;
  logic               xfer_s, release_s, swap_s;
  logic [PIXEL_W-1:0] rd_pixel_s;
  logic               unused_wdata_s;

  logic [PIXEL_W-1:0] bank0_mem [FRAME_PIXELS];
`ifdef FRAME_LOADER_PINGPONG_EN
  logic [PIXEL_W-1:0] bank1_mem [FRAME_PIXELS];
`endif

  assign xfer_s         = pixel_in_valid & ready_q;
  assign release_s      = classifier_input_valid_write_en & ~classifier_input_valid_write_data[0];
  assign unused_wdata_s = ^classifier_input_valid_write_data[7:1];

  // The last pixel sets commit_q; the commit itself (swap or HOLD) is decided one edge later,
  // with ready held low in between so no pixel lands in a bank that is about to change role.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    commit_d      = 1'b0;
    frame_err_d   = 1'b0;
    frame_count_d = frame_count_q;
    swap_s        = 1'b0;
    if (release_s) begin
      frame_valid_d = 1'b0;
    end else begin
      frame_valid_d = frame_valid_q;
    end
    case (state_q)
      FILL: begin
        if (commit_q) begin
          if (frame_valid_q) begin
            state_d = HOLD;
          end else begin
            frame_valid_d = 1'b1;
            swap_s        = 1'b1;
          end
        end else begin
          state_d = FILL;
        end
        if (xfer_s) begin
          if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d      = 10'd0;
            commit_d      = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            frame_err_d   = ~pixel_in_last;
          end else if (pixel_in_last) begin
            wr_ptr_d    = 10'd0;
            frame_err_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + 10'd1;
          end
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      HOLD: begin
        // Wait until the flag has read low for a full cycle before raising it for the next frame.
        if (!frame_valid_q && !valid_prev_q) begin
          state_d       = FILL;
          frame_valid_d = 1'b1;
          swap_s        = 1'b1;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
`ifdef FRAME_LOADER_PINGPONG_EN
    rd_bank_d = swap_s ? ~rd_bank_q : rd_bank_q;
    ready_d   = (state_d == FILL) && !commit_d;
`else
    rd_bank_d = 1'b0;
    ready_d   = (state_d == FILL) && !commit_d && !frame_valid_d;
`endif
  end

  always_comb begin
    rd_pixel_s = {PIXEL_W{1'b0}};
    if (classifier_input_address_a < DEPTH) begin
`ifdef FRAME_LOADER_PINGPONG_EN
      if (rd_bank_q) begin
        rd_pixel_s = bank1_mem[classifier_input_address_a];
      end else begin
        rd_pixel_s = bank0_mem[classifier_input_address_a];
      end
`else
      rd_pixel_s = bank0_mem[classifier_input_address_a];
`endif
    end else begin
      rd_pixel_s = {PIXEL_W{1'b0}};
    end
    rd_data_d = {{(16 - PIXEL_W){1'b0}}, rd_pixel_s};
  end

  // The fill bank is always the one the classifier is not reading.
  always_ff @(posedge clk) begin
`ifdef FRAME_LOADER_PINGPONG_EN
    if (xfer_s && rd_bank_q) begin
      bank0_mem[wr_ptr_q] <= pixel_in_data;
    end
    if (xfer_s && !rd_bank_q) begin
      bank1_mem[wr_ptr_q] <= pixel_in_data;
    end
`else
    if (xfer_s) begin
      bank0_mem[wr_ptr_q] <= pixel_in_data;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FILL;
      wr_ptr_q      <= 10'd0;
      rd_bank_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      valid_prev_q  <= 1'b0;
      commit_q      <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= 16'd0;
      ready_q       <= 1'b0;
      rd_data_q     <= 16'd0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_bank_q     <= rd_bank_d;
      frame_valid_q <= frame_valid_d;
      valid_prev_q  <= frame_valid_q;
      commit_q      <= commit_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
      ready_q       <= ready_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign pixel_in_ready                   = ready_q;
  assign classifier_input_read_data_a     = rd_data_q;
  assign classifier_input_valid_read_data = {7'b0000000, frame_valid_q};
  assign frame_err                        = frame_err_q;
  assign frame_count                      = frame_count_q;

endmodule

// File: tb/tb_digit_frame_loader.sv
// Self-checking bench for digit_frame_loader: read-address vector table plus a read scoreboard and frame sequences.
`timescale 1ns/1ps
module tb_digit_frame_loader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  pixel_in_data = 8'd0;
  logic        pixel_in_valid = 1'b0;
  logic        pixel_in_last = 1'b0;
  logic        pixel_in_ready;
  logic [9:0]  addr = 10'd0;
  logic [15:0] rdata;
  logic [7:0]  vflag;
  logic        wen = 1'b0;
  logic [7:0]  wdata = 8'd0;
  logic        frame_err;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;
  rd_vec_t vecs [8];

  always #5 clk = ~clk;

  digit_frame_loader dut (
    .clk                               (clk),
    .reset_n                           (reset_n),
    .pixel_in_data                     (pixel_in_data),
    .pixel_in_valid                    (pixel_in_valid),
    .pixel_in_last                     (pixel_in_last),
    .pixel_in_ready                    (pixel_in_ready),
    .classifier_input_address_a        (addr),
    .classifier_input_read_data_a      (rdata),
    .classifier_input_valid_read_data  (vflag),
    .classifier_input_valid_write_en   (wen),
    .classifier_input_valid_write_data (wdata),
    .frame_err                         (frame_err),
    .frame_count                       (frame_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one pixel from a negedge and hold it until a rising edge sees ready high.
  task automatic send_px(input logic [7:0] d, input logic l);
    bit done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      pixel_in_valid = 1'b1;
      pixel_in_data  = d;
      pixel_in_last  = l;
      if (pixel_in_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
    end
    if (!done) chk("send_px_timeout", 32'(done), 32'd1);
  endtask

  task automatic stream(input int n, input int base, input int last_at, input int first);
    for (int i = 0; i < n; i++) begin
      send_px((i == 0 && first >= 0) ? 8'(first) : 8'((base + i) % 256), (i == last_at));
    end
  endtask

  task automatic end_stream();
    @(negedge clk);
    pixel_in_valid = 1'b0;
    pixel_in_last  = 1'b0;
  endtask

  task automatic flag_write(input logic [7:0] d);
    @(negedge clk);
    wen   = 1'b1;
    wdata = d;
    @(negedge clk);
    wen   = 1'b0;
    wdata = 8'd0;
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk);
      if (vflag == 8'd1) seen = 1'b1;
    end
    if (!seen) chk("wait_valid_timeout", 32'(seen), 32'd1);
  endtask

  // Scoreboard read: expectation queued when the address is driven, popped when the registered data appears.
  task automatic rd(input logic [9:0] a, input logic [15:0] e);
    @(negedge clk);
    addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    chk($sformatf("rd@%0d", a), 32'(rdata), 32'(exp_q.pop_front()));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{10'd0,    16'h0000};
    vecs[1] = '{10'd5,    16'h0005};
    vecs[2] = '{10'd255,  16'h00FF};
    vecs[3] = '{10'd256,  16'h0000};
    vecs[4] = '{10'd783,  16'h000F};
    vecs[5] = '{10'd784,  16'h0000};
    vecs[6] = '{10'd800,  16'h0000};
    vecs[7] = '{10'd1023, 16'h0000};

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(pixel_in_ready), 32'd0);
    chk("rst_vflag", 32'(vflag), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(pixel_in_ready), 32'd1);

    // Frame 1: pixel i = i mod 256
    stream(784, 0, 783, -1);
    end_stream();
    chk("f1_err", 32'(frame_err), 32'd0);
    chk("f1_valid_latency", 32'(vflag), 32'd0);
    @(negedge clk);
    chk("f1_valid", 32'(vflag), 32'd1);
    chk("f1_count", 32'(frame_count), 32'd1);
    for (int i = 0; i < 8; i++) rd(vecs[i].addr, vecs[i].exp);

    flag_write(8'h01);
    chk("write1_ignored", 32'(vflag), 32'd1);

    // Frame B (base 100) without releasing frame A
`ifdef FRAME_LOADER_PINGPONG_EN
    stream(784, 100, 783, -1);
    end_stream();
    @(negedge clk);
    chk("hold_ready", 32'(pixel_in_ready), 32'd0);
    chk("hold_vflag", 32'(vflag), 32'd1);
    chk("hold_count", 32'(frame_count), 32'd2);
    rd(10'd10, 16'd10);
    flag_write(8'h00);
    chk("release_low", 32'(vflag), 32'd0);
    @(negedge clk);
    chk("hold_no_early_raise", 32'(vflag), 32'd0);
    wait_valid();
`else
    repeat (3) @(negedge clk);
    chk("single_stall", 32'(pixel_in_ready), 32'd0);
    flag_write(8'h00);
    chk("release_low", 32'(vflag), 32'd0);
    chk("release_ready", 32'(pixel_in_ready), 32'd1);
    stream(784, 100, 783, -1);
    end_stream();
    wait_valid();
`endif
    chk("b_count", 32'(frame_count), 32'd2);
    rd(10'd0, 16'd100);
    rd(10'd1, 16'd101);
    rd(10'd783, 16'd115);

    // Short frame: last on pixel 100
    flag_write(8'h00);
    chk("rel_b", 32'(vflag), 32'd0);
    stream(101, 0, 100, -1);
    end_stream();
    chk("short_err", 32'(frame_err), 32'd1);
    @(negedge clk);
    chk("short_err_pulse", 32'(frame_err), 32'd0);
    chk("short_count", 32'(frame_count), 32'd2);
    chk("short_no_commit", 32'(vflag), 32'd0);
    stream(784, 50, 783, -1);
    end_stream();
    chk("after_short_err", 32'(frame_err), 32'd0);
    wait_valid();
    chk("after_short_count", 32'(frame_count), 32'd3);
    rd(10'd1, 16'd51);
    rd(10'd700, 16'd238);

    // 784 pixels with no last: commit plus error
    flag_write(8'h00);
    stream(784, 7, -1, -1);
    end_stream();
    chk("nolast_err", 32'(frame_err), 32'd1);
    wait_valid();
    chk("nolast_count", 32'(frame_count), 32'd4);
    rd(10'd783, 16'd22);

    // Following pixel starts at address 0
    flag_write(8'h00);
    stream(784, 9, 783, 8'hAB);
    end_stream();
    wait_valid();
    chk("next_count", 32'(frame_count), 32'd5);
    rd(10'd0, 16'h00AB);
    rd(10'd1, 16'd10);
    rd(10'd800, 16'h0000);

    // Reset in the middle of a frame
`ifndef FRAME_LOADER_PINGPONG_EN
    flag_write(8'h00);
`endif
    stream(400, 0, -1, -1);
    @(negedge clk);
    pixel_in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(pixel_in_ready), 32'd0);
    chk("mid_rst_vflag", 32'(vflag), 32'd0);
    chk("mid_rst_err", 32'(frame_err), 32'd0);
    chk("mid_rst_count", 32'(frame_count), 32'd0);
    chk("mid_rst_rdata", 32'(rdata), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready_up", 32'(pixel_in_ready), 32'd1);
    stream(784, 200, 783, -1);
    end_stream();
    wait_valid();
    chk("fresh_count", 32'(frame_count), 32'd1);
    rd(10'd2, 16'd202);
    rd(10'd400, 16'd88);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/digit_frame_loader.md
# digit_frame_loader

Upstream stage of the digit-recognition classifier pipeline. Accepts a raster stream of 8-bit grayscale pixels (28x28 = 784 per frame, row-major) over a valid/ready handshake, assembles each frame in on-chip RAM, and presents the completed frame to the classifier through its memory-mapped input port: a 10-bit address / 16-bit read-data RAM port plus the 8-bit input-valid flag register. The block owns the flag's 0→1 transition; the classifier's write of 0 releases the frame.

## Interface
- FRAME_PIXELS, 784, pixels per frame; write pointer width is 10 bits.
- PIXEL_W, 8, pixel width; read data is zero-extended to 16 bits.
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pixel_in_data  in  8  pixel value.
- pixel_in_valid  in  1  pixel present.
- pixel_in_last  in  1  marks the final pixel of a frame.
- pixel_in_ready  out  1  loader can accept a pixel; transfer occurs when valid & ready.
- classifier_input_address_a  in  10  classifier read address.
- classifier_input_read_data_a  out  16  {8'b0, pixel}, registered.
- classifier_input_valid_read_data  out  8  {7'b0, frame_valid}.
- classifier_input_valid_write_en  in  1  classifier flag write strobe.
- classifier_input_valid_write_data  in  8  bit 0 = 0 releases the frame; writing 1 is ignored.
- frame_err  out  1  one-cycle pulse on a frame-length error.
- frame_count  out  16  frames committed since reset, wraps at 65535→0.

## Operation
- Storage: frame RAM banks of 784x8. Bank select `rd_bank` picks the bank the classifier reads; the fill bank is the other bank, or the same bank when single-buffered.
- Fill FSM states: FILL (ready=1, accepting) and HOLD (fill bank complete, waiting for a free read side; ready=0).
- FILL: on each transfer, write the pixel at `wr_ptr` and increment `wr_ptr`.
- FILL, pixel 784 accepted (wr_ptr==783): commit the frame, wr_ptr←0, frame_count+1.
  - If pixel_in_last=0 on that pixel, also pulse frame_err. The next pixel starts a new frame.
- FILL, pixel_in_last=1 with wr_ptr<783: discard the partial frame, wr_ptr←0, pulse frame_err, no commit.
- Commit when frame_valid=0: swap banks (ping-pong only), set frame_valid=1, stay in FILL.
- Commit when frame_valid=1: go to HOLD.
- HOLD → FILL: one cycle after frame_valid falls. Swap banks, set frame_valid=1.
- Release: classifier_input_valid_write_en with write_data[0]=0 clears frame_valid on the next edge.
- Read port: the registered data reflects `address_a` from the previous cycle on `rd_bank`. Addresses ≥784 read 0.

## Timing
- Reset values:
  - pixel_in_ready=0 during reset; 1 in the first cycle after reset_n rises.
  - read_data_a=0, frame_valid=0, frame_err=0, frame_count=0.
  - wr_ptr=0, rd_bank=0, state=FILL.
- Reset mid-frame clears all pointers and flags. RAM contents are not cleared.
- Read latency: 1 cycle.
- Commit latency: 784th pixel accepted at edge N → frame_valid=1 after edge N+1 when the read side is free.
- Release at edge N → frame_valid=0 visible for at least one cycle. A pending (HOLD) frame raises frame_valid no earlier than edge N+2, so the same flag is never re-read as 1 for the old frame.
- A release and a commit in the same cycle: the release takes effect and the commit goes to HOLD.
- frame_err is registered and asserts the cycle after the offending transfer.

## Configuration
- FRAME_LOADER_PINGPONG_EN defined: two banks. Filling continues while the classifier reads, and HOLD is reached only when a second full frame waits.
- FRAME_LOADER_PINGPONG_EN undefined: one bank. pixel_in_ready=0 whenever frame_valid=1 or the state is HOLD, so the frame being read is never overwritten. rd_bank is constant 0.

## Test plan
- Reset, then stream 784 pixels with value (i mod 256) and last on pixel 783. Expect: frame_valid=1 one cycle after the last transfer; read of address 5 returns 16'h0005 one cycle later; frame_count=1.
- Stream frame A, then frame B, with no release. Expect: ping-pong: B is accepted fully, then ready=0 (HOLD); single-bank: ready=0 right after A. Release → flag low ≥1 cycle → flag high with B's data; frame_count=2.
- Assert last on pixel 100. Expect: frame_err pulse, no commit, frame_count unchanged; the next 784-pixel frame commits normally.
- Send 784 pixels with last=0 throughout. Expect: commit plus a frame_err pulse; pixel 785 is stored at address 0.
- Read address 800 while valid. Expect: read_data 16'h0000.
- Assert reset_n low at pixel 400 of frame 2 while frame 1 is valid. Expect: all outputs at reset values immediately; after reset, a fresh frame commits with frame_count=1.
